// File: rtl/periph_bus.sv
// periph_bus: single-master bus bridge with address decode, per-slave select,
// completion/timeout tracking and a one-cycle response pulse.
module periph_bus #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_0000}}
) (
  input  logic                         CLK_CPU,
  input  logic                         resetp,
  input  logic                         m_en,
  input  logic                         m_we,
  input  logic [1:0]                   m_size,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_rvalid,
  output logic                         m_wready,
  output logic                         m_err,
  output logic                         m_busy,
  output logic [NUM_SLAVES-1:0]        s_en,
  output logic                         s_we,
  output logic [1:0]                   s_size,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_done
);
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_sel, w_idx;
  logic w_hit, w_done, w_tout;
  logic [7:0] r_cnt;
  logic r_err;
  logic [DATA_W-1:0] r_rdata;
  // Scan from the top down so the lowest matching index is the last to win.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = SW'(i);
      end
  end
  assign w_done = s_done[r_sel];
  assign w_tout = r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state == IDLE   ? (m_en ? (w_hit ? ACCESS : RESP) : IDLE)
           : r_state == ACCESS ? ((w_done || w_tout) ? RESP : ACCESS)
           : IDLE;
  end
  always_ff @(posedge CLK_CPU or posedge resetp)
    if (resetp) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLK_CPU or posedge resetp) begin
    if (resetp) begin
      r_sel <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_rdata <= '0;
      s_we <= 1'b0;
      s_size <= '0;
      s_addr <= '0;
      s_wdata <= '0;
    end else if (r_state == IDLE) begin
      if (m_en && w_hit) begin
        r_sel <= w_idx;
        r_cnt <= '0;
        r_err <= 1'b0;
        r_rdata <= '0;
        s_we <= m_we;
        s_size <= m_size;
        s_addr <= m_addr;
        s_wdata <= m_wdata;
      end else if (m_en) begin
        r_err <= 1'b1;
        r_rdata <= '0;
      end
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 8'd1;
      if (w_done) begin
        r_err <= 1'b0;
        r_rdata <= s_we ? '0 : s_rdata[r_sel*DATA_W +: DATA_W];
      end else if (w_tout) begin
        r_err <= 1'b1;
        r_rdata <= '0;
      end
    end
  end
  assign m_busy = r_state != IDLE;
  assign s_en = (r_state == ACCESS) ? (NUM_SLAVES'(1) << r_sel) : '0;
  assign m_rvalid = r_state == RESP && !r_err && !s_we;
  assign m_wready = r_state == RESP && !r_err && s_we;
  assign m_err = r_state == RESP && r_err;
  assign m_rdata = m_rvalid ? r_rdata : '0;
endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: directed and randomized transactions checked against a
// transaction-level model of decode, completion, timeout and reset behaviour.
module tb_periph_bus;
  localparam int TIMEOUT = 16;
  localparam int NEVER = 1000;
  logic CLK_CPU = 1'b0;
  logic resetp;
  logic m_en, m_we;
  logic [1:0] m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic m_rvalid, m_wready, m_err, m_busy;
  logic [3:0] s_en;
  logic s_we;
  logic [1:0] s_size;
  logic [31:0] s_addr, s_wdata;
  logic [127:0] s_rdata;
  logic [3:0] s_done;
  int n_cmp = 0;
  int n_fail = 0;

  periph_bus #(.TIMEOUT(TIMEOUT)) dut (
    .CLK_CPU(CLK_CPU), .resetp(resetp), .m_en(m_en), .m_we(m_we), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_wready(m_wready), .m_err(m_err), .m_busy(m_busy), .s_en(s_en), .s_we(s_we),
    .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  task automatic step;
    @(posedge CLK_CPU);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] en, input bit busy, input bit rv,
                         input bit wr, input bit er, input logic [31:0] rd);
    chk({tag, ".s_en"}, 128'(s_en), 128'(en));
    chk({tag, ".m_busy"}, 128'(m_busy), 128'(busy));
    chk({tag, ".m_rvalid"}, 128'(m_rvalid), 128'(rv));
    chk({tag, ".m_wready"}, 128'(m_wready), 128'(wr));
    chk({tag, ".m_err"}, 128'(m_err), 128'(er));
    chk({tag, ".m_rdata"}, 128'(m_rdata), 128'(rd));
  endtask

  // Reference decode: 64 KiB windows at 0x0000_0000..0x0003_0000, lowest index first.
  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & 32'hFFFF_0000) == (32'(i) << 16)) return i;
    return -1;
  endfunction

  // One transaction starting in an IDLE cycle; k is the cycle (after m_en) at
  // which the selected slave completes. Ends in the IDLE cycle after RESP.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input int k, input logic [31:0] d);
    int sel, t;
    bit er;
    logic [1:0] sz;
    sel = ref_sel(addr);
    sz = 2'($urandom);
    m_en = 1'b1; m_we = we; m_size = sz; m_addr = addr; m_wdata = wd;
    step;
    m_en = 1'b0;
    if (sel < 0) begin
      chk_out("miss", 4'b0, 1, 0, 0, 1, 32'h0);
      m_en = 1'($urandom); m_addr = $urandom & 32'h0003_FFFF;
    end else begin
      t = (k <= TIMEOUT) ? k : TIMEOUT;
      for (int c = 1; c <= t; c++) begin
        chk_out("access", 4'b0001 << sel, 1, 0, 0, 0, 32'h0);
        chk("latched", {61'h0, s_we, s_size, s_addr, s_wdata}, {61'h0, we, sz, addr, wd});
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        s_done = 4'($urandom) & ~(4'b0001 << sel);
        if (c == k) begin
          s_done[sel] = 1'b1;
          s_rdata[sel*32 +: 32] = d;
        end
        m_en = 1'($urandom); m_we = 1'($urandom);
        m_addr = $urandom & 32'h0003_FFFF; m_wdata = $urandom;
        step;
      end
      s_done = 4'b0;
      m_en = 1'($urandom); m_addr = $urandom & 32'h0003_FFFF;
      er = k > TIMEOUT;
      chk_out("resp", 4'b0, 1, !er && !we, !er && we, er, (!er && !we) ? d : 32'h0);
    end
    step;
    m_en = 1'b0;
    chk_out("idle", 4'b0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    int k;
    logic [31:0] a;
    resetp = 1'b1; m_en = 1'b0; m_we = 1'b0; m_size = 2'b0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_done = '0;
    #1;
    chk_out("reset", 4'b0, 0, 0, 0, 0, 32'h0);
    chk("reset.s_regs", {61'h0, s_we, s_size, s_addr, s_wdata}, 128'h0);
    step; step;
    resetp = 1'b0;
    step;
    txn(1'b0, 32'h0001_0004, 32'h0, 3, 32'hDEAD_BEEF);
    txn(1'b1, 32'h0002_0000, 32'h1234_5678, 1, 32'h0);
    txn(1'b0, 32'h0009_0000, 32'h0, 1, 32'h0);
    txn(1'b0, 32'h0003_0000, 32'h0, NEVER, 32'h0);
    txn(1'b0, 32'h0000_0010, 32'h0, 5, 32'hCAFE_F00D);
    txn(1'b0, 32'h0002_0020, 32'h0, TIMEOUT, 32'h5A5A_A5A5);
    txn(1'b1, 32'h0001_0000, 32'h0BAD_F00D, TIMEOUT + 1, 32'h0);
    txn(1'b0, 32'hFFFF_FFFF, 32'h0, 1, 32'h0);
    // Reset in the second ACCESS cycle: abort silently, then resume normally.
    m_en = 1'b1; m_we = 1'b0; m_addr = 32'h0001_0004; m_wdata = 32'h7777_0000;
    step;
    m_en = 1'b0;
    step;
    chk("rst_pre.s_en", 128'(s_en), 128'(4'b0010));
    resetp = 1'b1;
    #1;
    chk_out("rst_async", 4'b0, 0, 0, 0, 0, 32'h0);
    chk("rst_async.s_regs", {61'h0, s_we, s_size, s_addr, s_wdata}, 128'h0);
    s_done = 4'b0010; s_rdata = {4{32'h1111_2222}};
    step;
    resetp = 1'b0;
    step;
    chk_out("rst_after", 4'b0, 0, 0, 0, 0, 32'h0);
    s_done = 4'b0;
    txn(1'b0, 32'h0001_0008, 32'h0, 2, 32'h600D_DA7A);
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 4) == 4) ? {16'($urandom_range(4, 16'hFFFF)), 16'($urandom)}
                                      : {16'($urandom_range(0, 3)), 16'($urandom)};
      k = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(1, TIMEOUT + 4);
      txn(1'($urandom), a, $urandom, k, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
